// File: rtl/timetag_uart_pkg.sv
// Shared definitions for the buffered timetag UART streamer.
package timetag_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_SEND_BYTE,
    ST_WAIT_BYTE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned FRAME_BITS          = 10;
  localparam logic [7:0]  HEADER_BYTE_DEFAULT = 8'hA5;

  // Width of an occupancy count that must reach DEPTH itself
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_word_streamer_word_fifo.sv
// Synchronous word FIFO with occupancy count; storage is not reset.
module word_fifo
  import timetag_uart_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_streamer.sv
// Buffers timetag words and streams each as a sequence of 8N1 UART frames,
// optionally preceded by a header byte.
module uart_word_streamer
  import timetag_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_BYTES = 6,
  parameter int unsigned CLKS_PER_BIT     = 434,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned MSB_FIRST        = 0,
  parameter int unsigned HEADER_EN        = 0,
  parameter logic [7:0]  HEADER_BYTE      = HEADER_BYTE_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DATA_WIDTH_BYTES*8-1:0]      data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  output logic                               tx_out,
  output logic                               transmission_over,
  output logic                               busy,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
  output logic                               overflow,
  input  logic                               overflow_clear
);

  localparam int unsigned WORD_W = DATA_WIDTH_BYTES * 8;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH_BYTES + 1);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS);

  state_e                  state;
  logic [WORD_W-1:0]       word_sr;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    hdr_gap;
  logic                    ser_busy;
  logic [FRAME_BITS-1:0]   frame_sr;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WORD_W-1:0]       head_word;
  logic                    push_c;
  logic                    pop_c;
  logic                    ser_start_c;
  logic [7:0]              ser_byte_c;
  logic [WORD_W-1:0]       word_shift_c;

  function automatic logic [7:0] lead_byte(input logic [WORD_W-1:0] w);
    if (MSB_FIRST != 0) return w[WORD_W-1 -: 8];
    else                return w[7:0];
  endfunction

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_c),
    .push_data (data_in),
    .pop       (pop_c),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign data_ready = !fifo_full;

  // Frame launches happen on the edge entering HEADER/SEND_BYTE so the start
  // bit is already on the line in that state.
  always_comb begin
    push_c       = data_valid && !fifo_full;
    pop_c        = (state == ST_LOAD);
    word_shift_c = (MSB_FIRST != 0) ? (word_sr << 8) : (word_sr >> 8);
    ser_start_c  = 1'b0;
    ser_byte_c   = lead_byte(word_sr);
    case (state)
      ST_LOAD: begin
        ser_start_c = 1'b1;
        ser_byte_c  = (HEADER_EN != 0) ? HEADER_BYTE : lead_byte(head_word);
      end
      ST_SHIFT: begin
        ser_start_c = 1'b1;
        ser_byte_c  = lead_byte(word_shift_c);
      end
      ST_HEADER: begin
        ser_start_c = hdr_gap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      overflow <= 1'b0;
    else if (data_valid && fifo_full)  overflow <= 1'b1;
    else if (overflow_clear)           overflow <= 1'b0;
  end

  // Bit serialiser: ser_busy drops on the cycle after the stop bit completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_out   <= 1'b1;
      ser_busy <= 1'b0;
      frame_sr <= '1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (ser_start_c) begin
      frame_sr <= {1'b1, ser_byte_c, 1'b0};
      tx_out   <= 1'b0;
      ser_busy <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (ser_busy) begin
      if (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) begin
        baud_cnt <= '0;
        if (bit_idx == BIT_W'(FRAME_BITS - 1)) begin
          ser_busy <= 1'b0;
          tx_out   <= 1'b1;
        end else begin
          bit_idx  <= bit_idx + BIT_W'(1);
          frame_sr <= {1'b1, frame_sr[FRAME_BITS-1:1]};
          tx_out   <= frame_sr[1];
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

  // Word sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      word_sr           <= '0;
      byte_cnt          <= '0;
      hdr_gap           <= 1'b0;
      transmission_over <= 1'b0;
      busy              <= 1'b0;
    end else begin
      transmission_over <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          word_sr  <= head_word;
          byte_cnt <= CNT_W'(DATA_WIDTH_BYTES);
          state    <= (HEADER_EN != 0) ? ST_HEADER : ST_SEND_BYTE;
        end
        ST_HEADER: begin
          // one extra idle cycle keeps the inter-byte gap at two cycles
          if (hdr_gap) begin
            hdr_gap <= 1'b0;
            state   <= ST_SEND_BYTE;
          end else if (!ser_busy) begin
            hdr_gap <= 1'b1;
          end
        end
        ST_SEND_BYTE: state <= ST_WAIT_BYTE;
        ST_WAIT_BYTE: begin
          if (!ser_busy) begin
            if (byte_cnt == CNT_W'(1)) begin
              state             <= ST_DONE;
              transmission_over <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          word_sr  <= word_shift_c;
          byte_cnt <= byte_cnt - CNT_W'(1);
          state    <= ST_SEND_BYTE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_streamer.sv
// Self-checking bench: UART line receivers plus a byte-stream/timing model.
`timescale 1ns/1ps
module tb_uart_word_streamer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DWB   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, rst_b;
  logic [15:0] a_din, b_din;
  logic        a_valid, b_valid, a_clr, b_clr;
  logic        a_ready, b_ready, a_tx, b_tx, a_over, b_over, a_busy, b_busy, a_ovf, b_ovf;
  logic [2:0]  a_level, b_level;

  uart_word_streamer #(.DATA_WIDTH_BYTES(DWB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
                       .MSB_FIRST(0), .HEADER_EN(0), .HEADER_BYTE(8'hA5)) dut_a (
    .clk(clk), .reset_n(rst_a), .data_in(a_din), .data_valid(a_valid), .data_ready(a_ready),
    .tx_out(a_tx), .transmission_over(a_over), .busy(a_busy), .fifo_level(a_level),
    .overflow(a_ovf), .overflow_clear(a_clr));

  uart_word_streamer #(.DATA_WIDTH_BYTES(DWB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
                       .MSB_FIRST(1), .HEADER_EN(1), .HEADER_BYTE(8'hA5)) dut_b (
    .clk(clk), .reset_n(rst_b), .data_in(b_din), .data_valid(b_valid), .data_ready(b_ready),
    .tx_out(b_tx), .transmission_over(b_over), .busy(b_busy), .fifo_level(b_level),
    .overflow(b_ovf), .overflow_clear(b_clr));

  int checks = 0;
  int failures = 0;

  logic [7:0] rxq_a[$], rxq_b[$], expq[$];
  int         rxs_a[$], rxs_b[$], ovq_a[$], ovq_b[$];
  int         ferr_a = 0, ferr_b = 0;

  function automatic logic tx_of(input int ch);
    return (ch == 0) ? a_tx : b_tx;
  endfunction

  function automatic logic rst_of(input int ch);
    return (ch == 0) ? rst_a : rst_b;
  endfunction

  // Receiver: every cycle of each bit must hold the same level; frames cut by reset are discarded
  task automatic rx_loop(input int ch);
    logic [7:0] d;
    int st;
    bit ok, abort, v, first;
    forever begin
      @(negedge clk);
      if (rst_of(ch) && tx_of(ch) == 1'b0) begin
        st = cyc; ok = 1; abort = 0; d = '0; first = 0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c < int'(CPB) && !abort; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_of(ch)) abort = 1;
            else begin
              v = tx_of(ch);
              if (c == 0) first = v;
              else if (v != first) ok = 0;
              if (c == int'(CPB / 2)) begin
                if (b == 0 && v != 1'b0) ok = 0;
                else if (b == 9 && v != 1'b1) ok = 0;
                else if (b >= 1 && b <= 8) d[b-1] = v;
              end
            end
          end
        end
        if (!abort) begin
          if (ch == 0) begin rxq_a.push_back(d); rxs_a.push_back(st); if (!ok) ferr_a++; end
          else         begin rxq_b.push_back(d); rxs_b.push_back(st); if (!ok) ferr_b++; end
        end
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  always @(negedge clk) begin
    if (a_over === 1'b1) ovq_a.push_back(cyc);
    if (b_over === 1'b1) ovq_b.push_back(cyc);
  end

  // Reference: byte order and header derived arithmetically from the word
  function automatic void add_exp(input int ch, input logic [15:0] w);
    int sh;
    if (ch == 1) expq.push_back(8'hA5);
    for (int k = 0; k < int'(DWB); k++) begin
      sh = (ch == 0) ? k : int'(DWB) - 1 - k;
      expq.push_back(8'((w >> (8 * sh)) & 16'h00FF));
    end
  endfunction

  function automatic void clear_q();
    rxq_a.delete(); rxq_b.delete(); rxs_a.delete(); rxs_b.delete();
    ovq_a.delete(); ovq_b.delete(); expq.delete();
    ferr_a = 0; ferr_b = 0;
  endfunction

  task automatic push(input int ch, input logic [15:0] w, output int c0);
    @(negedge clk);
    if (ch == 0) begin a_din = w; a_valid = 1'b1; end
    else         begin b_din = w; b_valid = 1'b1; end
    c0 = cyc;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int ch, input int n, input int budget, input string nm);
    for (int i = 0; i < budget && ((ch == 0) ? ovq_a.size() : ovq_b.size()) < n; i++) @(negedge clk);
    checks++;
    if (((ch == 0) ? ovq_a.size() : ovq_b.size()) < n) begin
      failures++;
      $display("FAIL %s_timeout pulses=%0d required=%0d", nm, (ch == 0) ? ovq_a.size() : ovq_b.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    a_valid = 0; b_valid = 0; a_clr = 0; b_clr = 0; a_din = '0; b_din = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL rst_hold_tx got=%b exp=1", a_tx); end
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", a_tx); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", a_ready); end
    checks++; if (a_over !== 1'b0) begin failures++; $display("FAIL rst_over got=%b exp=0", a_over); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
    checks++; if (a_level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", a_level); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", a_ovf); end
    checks++; if (b_tx !== 1'b1 || b_busy !== 1'b0) begin failures++; $display("FAIL rst_b tx=%b busy=%b exp=1,0", b_tx, b_busy); end
  endtask

  task automatic test_basic_framing();
    int c0;
    logic [15:0] w;
    for (int n = 0; n < 5; n++) begin
      clear_q();
      w = (n == 0) ? 16'hBEEF : 16'($urandom);
      add_exp(0, w);
      push(0, w, c0);
      if (n == 0) begin
        checks++; if (a_level !== 3'd1) begin failures++; $display("FAIL basic_level1 got=%0d exp=1", a_level); end
      end
      wait_pulses(0, 1, 300, "basic");
      repeat (4) @(negedge clk);
      checks++;
      if (rxq_a.size() != expq.size()) begin
        failures++; $display("FAIL basic_nbytes got=%0d exp=%0d", rxq_a.size(), expq.size());
      end else begin
        for (int i = 0; i < expq.size(); i++) begin
          checks++; if (rxq_a[i] !== expq[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, rxq_a[i], expq[i]); end
        end
        checks++; if (rxs_a[0] != c0 + 3) begin failures++; $display("FAIL basic_start got=%0d exp=%0d", rxs_a[0], c0 + 3); end
        checks++; if (rxs_a[1] != rxs_a[0] + FRAME + 2) begin failures++; $display("FAIL basic_gap got=%0d exp=%0d", rxs_a[1] - rxs_a[0], FRAME + 2); end
        if (ovq_a.size() > 0) begin
          checks++; if (ovq_a[0] - rxs_a[0] != 2 * FRAME + 3) begin failures++; $display("FAIL basic_duration got=%0d exp=%0d", ovq_a[0] - rxs_a[0], 2 * FRAME + 3); end
        end
      end
      checks++; if (ovq_a.size() != 1) begin failures++; $display("FAIL basic_pulse_cycles got=%0d exp=1", ovq_a.size()); end
      checks++; if (ferr_a != 0) begin failures++; $display("FAIL basic_framing errors=%0d exp=0", ferr_a); end
      checks++; if (a_busy !== 1'b0 || a_level !== 3'd0) begin failures++; $display("FAIL basic_idle busy=%b level=%0d exp=0,0", a_busy, a_level); end
    end
  endtask

  task automatic test_header_order();
    int c0, cfirst;
    logic [15:0] w;
    clear_q();
    for (int n = 0; n < 3; n++) begin
      w = (n == 0) ? 16'h1234 : 16'($urandom);
      add_exp(1, w);
      push(1, w, c0);
      if (n == 0) cfirst = c0;
    end
    wait_pulses(1, 3, 600, "header");
    repeat (4) @(negedge clk);
    checks++;
    if (rxq_b.size() != expq.size()) begin
      failures++; $display("FAIL hdr_nbytes got=%0d exp=%0d", rxq_b.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++; if (rxq_b[i] !== expq[i]) begin failures++; $display("FAIL hdr_byte%0d got=%h exp=%h", i, rxq_b[i], expq[i]); end
      end
      checks++; if (rxs_b[0] != cfirst + 3) begin failures++; $display("FAIL hdr_start got=%0d exp=%0d", rxs_b[0], cfirst + 3); end
      checks++; if (ovq_b[0] - rxs_b[0] != 3 * FRAME + 5) begin failures++; $display("FAIL hdr_duration got=%0d exp=%0d", ovq_b[0] - rxs_b[0], 3 * FRAME + 5); end
    end
    checks++; if (ferr_b != 0) begin failures++; $display("FAIL hdr_framing errors=%0d exp=0", ferr_b); end
  endtask

  task automatic test_burst_overflow();
    int lvl, nacc;
    bit acc;
    clear_q();
    @(negedge clk); a_clr = 1'b1; @(negedge clk); a_clr = 1'b0;
    lvl = 0; nacc = 0;
    for (int i = 0; i < 6; i++) begin
      a_din = 16'(i + 1); a_valid = 1'b1;
      acc = (lvl < int'(DEPTH));
      checks++; if (a_ready !== acc) begin failures++; $display("FAIL burst_ready%0d got=%b exp=%b", i, a_ready, acc); end
      if (acc) begin add_exp(0, 16'(i + 1)); nacc++; end
      lvl = lvl + int'(acc) - ((i == 2) ? 1 : 0);
      @(negedge clk);
    end
    a_valid = 1'b0;
    checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL burst_ovf got=%b exp=1", a_ovf); end
    checks++; if (a_level !== 3'(lvl)) begin failures++; $display("FAIL burst_level got=%0d exp=%0d", a_level, lvl); end
    wait_pulses(0, nacc, 800, "burst");
    repeat (4) @(negedge clk);
    checks++;
    if (rxq_a.size() != expq.size()) begin
      failures++; $display("FAIL burst_nbytes got=%0d exp=%0d", rxq_a.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++; if (rxq_a[i] !== expq[i]) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, rxq_a[i], expq[i]); end
      end
    end
    checks++; if (a_level !== 3'd0) begin failures++; $display("FAIL burst_drained got=%0d exp=0", a_level); end
    checks++; if (ferr_a != 0) begin failures++; $display("FAIL burst_framing errors=%0d exp=0", ferr_a); end
  endtask

  task automatic test_overflow_collision();
    logic [15:0] w;
    clear_q();
    @(negedge clk); a_clr = 1'b1; @(negedge clk); a_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom); a_din = w; a_valid = 1'b1; add_exp(0, w);
      @(negedge clk);
    end
    a_din = 16'hDEAD; a_valid = 1'b1; a_clr = 1'b1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL coll_full_ready got=%b exp=0", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", a_ovf); end
    @(negedge clk);
    a_clr = 1'b0;
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b exp=0", a_ovf); end
    wait_pulses(0, 5, 800, "coll");
    repeat (4) @(negedge clk);
    checks++;
    if (rxq_a.size() != expq.size()) begin
      failures++; $display("FAIL coll_nbytes got=%0d exp=%0d", rxq_a.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++; if (rxq_a[i] !== expq[i]) begin failures++; $display("FAIL coll_byte%0d got=%h exp=%h", i, rxq_a[i], expq[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int ts, c0;
    logic [15:0] w;
    clear_q();
    for (int i = 0; i < 6; i++) begin
      a_din = 16'($urandom); a_valid = 1'b1; @(negedge clk);
    end
    a_valid = 1'b0;
    ts = -1;
    for (int i = 0; i < 20 && ts < 0; i++) begin
      if (a_tx === 1'b0) ts = cyc; else @(negedge clk);
    end
    checks++; if (ts < 0) begin failures++; $display("FAIL rmid_no_start got=none exp=start_bit"); end
    while (ts >= 0 && cyc < ts + 3 * int'(CPB) + 1) @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL rmid_tx got=%b exp=1", a_tx); end
    checks++; if (a_level !== 3'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", a_level); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", a_busy); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0", a_ovf); end
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    clear_q();
    repeat (3) @(negedge clk);
    checks++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL rmid_no_resume tx=%b busy=%b exp=1,0", a_tx, a_busy); end
    w = 16'($urandom);
    add_exp(0, w);
    push(0, w, c0);
    wait_pulses(0, 1, 300, "rmid");
    repeat (4) @(negedge clk);
    checks++;
    if (rxq_a.size() != 2) begin
      failures++; $display("FAIL rmid_nbytes got=%0d exp=2", rxq_a.size());
    end else begin
      checks++; if (rxq_a[0] !== expq[0] || rxq_a[1] !== expq[1]) begin failures++; $display("FAIL rmid_bytes got=%h%h exp=%h%h", rxq_a[1], rxq_a[0], expq[1], expq[0]); end
      checks++; if (rxs_a[0] != c0 + 3) begin failures++; $display("FAIL rmid_start got=%0d exp=%0d", rxs_a[0], c0 + 3); end
    end
    checks++; if (ferr_a != 0) begin failures++; $display("FAIL rmid_framing errors=%0d exp=0", ferr_a); end
  endtask

  task automatic test_back_to_back();
    int c0, gap;
    logic [15:0] w;
    clear_q();
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom); a_din = w; a_valid = 1'b1; add_exp(0, w);
      @(negedge clk);
    end
    a_valid = 1'b0;
    wait_pulses(0, 3, 600, "b2b");
    repeat (4) @(negedge clk);
    checks++; if (ovq_a.size() != 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", ovq_a.size()); end
    checks++;
    if (rxq_a.size() != expq.size()) begin
      failures++; $display("FAIL b2b_nbytes got=%0d exp=%0d", rxq_a.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++; if (rxq_a[i] !== expq[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rxq_a[i], expq[i]); end
      end
      checks++; if (rxs_a[0] != c0 + 3) begin failures++; $display("FAIL b2b_start got=%0d exp=%0d", rxs_a[0], c0 + 3); end
      for (int k = 0; k < 2; k++) begin
        gap = rxs_a[2 * k + 2] - (rxs_a[2 * k + 1] + FRAME);
        checks++; if (gap < 3) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp>=3", k, gap); end
      end
    end
    checks++; if (ferr_a != 0) begin failures++; $display("FAIL b2b_framing errors=%0d exp=0", ferr_a); end
  endtask

  initial begin
    test_reset();
    test_basic_framing();
    test_header_order();
    test_burst_overflow();
    test_overflow_collision();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_streamer.md
# uart_word_streamer

Buffered, parametrised successor to the single-word UART serialiser. Accepts timetag words over a valid/ready handshake into an internal FIFO and streams each word as `DATA_WIDTH_BYTES` 8N1 UART frames, with selectable byte order and an optional per-word header byte. Sits between the timetag capture logic and the board's TX pin, so event bursts are absorbed without per-word triggering or lost data.

## Interface
- `DATA_WIDTH_BYTES`, 6: bytes per word; ≥1.
- `CLKS_PER_BIT`, 434: clk cycles per UART bit; ≥2.
- `FIFO_DEPTH`, 16: word slots; power of two, ≥2.
- `MSB_FIRST`, 0: 0 = byte [7:0] sent first, 1 = top byte first.
- `HEADER_EN`, 0: 1 = send `HEADER_BYTE` before each word.
- `HEADER_BYTE`, 8'hA5: header value.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_in` in DATA_WIDTH_BYTES*8: word to enqueue.
- `data_valid` in 1: `data_in` valid this cycle.
- `data_ready` out 1: FIFO not full.
- `tx_out` out 1: UART serial line, idle high.
- `transmission_over` out 1: one-cycle pulse after a word's last stop bit.
- `busy` out 1: FSM not in IDLE.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: words stored.
- `overflow` out 1: sticky; a word was offered while full.
- `overflow_clear` in 1: clears `overflow`.

## Operation
- Reset values: `tx_out`=1, `data_ready`=1, `transmission_over`=0, `busy`=0, `fifo_level`=0, `overflow`=0; FIFO empty, FSM IDLE.
- Enqueue when `data_valid && data_ready`. `data_ready` = !full, computed from the current level; a word offered while full is not stored even if a pop occurs the same cycle. It is dropped and sets `overflow`.
- `overflow`: set on a drop, cleared by `overflow_clear`. If both happen in the same cycle, set wins.
- FSM states: IDLE, LOAD, HEADER, SEND_BYTE, WAIT_BYTE, SHIFT, DONE.
  - IDLE→LOAD when FIFO not empty.
  - LOAD pops the head into the word shift register and loads the byte counter with DATA_WIDTH_BYTES. Then →HEADER if `HEADER_EN`, else →SEND_BYTE.
  - HEADER starts a frame with `HEADER_BYTE`, waits for frame end, then →SEND_BYTE.
  - SEND_BYTE starts a frame with the current byte (low byte, or top byte if `MSB_FIRST`), then →WAIT_BYTE.
  - WAIT_BYTE at frame end: if the counter has expired →DONE, else →SHIFT.
  - SHIFT shifts the word by 8 bits toward the selected end, decrements the counter, then →SEND_BYTE.
  - DONE pulses `transmission_over`, then →IDLE.
- Frame: start 0, data LSB-first, stop 1; each bit lasts exactly `CLKS_PER_BIT` cycles.
- Between bytes of a word, `tx_out` is held high for 2 cycles (SHIFT, SEND_BYTE). Between words, it is held high for at least 3 cycles (DONE, IDLE, LOAD).
- Asserting `reset_n` mid-frame aborts immediately: `tx_out`=1, FIFO flushed, `overflow` cleared. The partial frame is not resumed.

## Timing
- Word accepted at cycle 0 into an empty FIFO with FSM IDLE:
  - `fifo_level`=1 at cycle 1.
  - LOAD at cycle 2.
  - Start bit on `tx_out` from cycle 3 (HEADER or SEND_BYTE).
- Per-word duration, N = DATA_WIDTH_BYTES + HEADER_EN: N*10*CLKS_PER_BIT + 2*(N-1) + 1 cycles from the first start bit to the `transmission_over` pulse.
- `fifo_level` updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `transmission_over` is high for exactly one cycle per word.

## Structure
- Shared package `timetag_uart_pkg` holds the FSM state encoding, the frame length constant (10 bits), the header default, and the `fifo_level` width function.
- One sub-module: `word_fifo`, a synchronous FIFO with async active-low reset.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, full, empty, level.
- The bit-serialiser (baud counter, bit index, frame shift register) is implemented inside this block with the same reset, not by instancing the legacy transmitter. This keeps `tx_out` defined during and after reset.

## Test plan
- Basic framing: CLKS_PER_BIT=4, DATA_WIDTH_BYTES=2, MSB_FIRST=0; push 16'hBEEF. Expect bytes EF then BE, each framed 0,LSB..MSB,1 at 4 cycles/bit. Expect `transmission_over` 1 cycle after the second stop bit; total 83 cycles from the first start bit.
- Byte order and header: MSB_FIRST=1, HEADER_EN=1; push 16'h1234. Expect the byte stream A5,12,34.
- Burst and overflow: FIFO_DEPTH=4; push 6 consecutive words 1..6 with `data_valid` held high. Expect `data_ready` low once full and `overflow`=1. Expect the transmitted words to be exactly the accepted ones, in order, and `fifo_level` back to 0 at the end.
- Overflow set/clear collision: offer a word while full in the same cycle as `overflow_clear`. Expect `overflow` to remain 1. Pulse `overflow_clear` alone; expect `overflow`=0 the next cycle.
- Reset mid-frame: deassert `reset_n` during bit 3 of byte 1. Expect `tx_out`=1 asynchronously, `fifo_level`=0, `busy`=0. After release, push a new word; expect clean transmission.
- Back-to-back words: push 3 words while idle. Expect 3 `transmission_over` pulses and ≥3 idle-high cycles between each word's last stop bit and the next start bit.
